hazard_unit: RTL

Parametrised pipeline hazard and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It keeps shadow copies of per-stage instruction metadata (valid, rd, write-enable, load flag) and generates the following pipeline-wide controls:
- stall, bubble and flush controls;
- operand-forwarding selects for the EX stage ALU muxes.

Its input is decoded ID-stage fields, cache stall lines and the EX-stage redirect. It supports a forwarding mode and a stall-only mode, plus hazard performance counters.

---
 rtl/hazard_unit_pkg.sv | 21 ++
 rtl/hazard_stage_meta.sv | 32 +++
 rtl/hazard_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared types for the pipeline hazard/forwarding controller
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_EX_MEM  = 2'b01,
        FWD_MEM_WB  = 2'b10
    } fwdmux_sel_t;

    // MEM outranks WB because it holds the younger result for the same register.
    function automatic fwdmux_sel_t fwd_select(input logic en, input logic mem_hit, input logic wb_hit);
        if (!en)
            return FWD_REGFILE;
        if (mem_hit)
            return FWD_EX_MEM;
        if (wb_hit)
            return FWD_MEM_WB;
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/hazard_stage_meta.sv
// rtl/hazard_stage_meta.sv - loadable, reset-clearable per-stage instruction metadata register
module hazard_stage_meta #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rd,
    input  logic          d_we,
    input  logic          d_is_load,
    output logic          q_valid,
    output logic [AW-1:0] q_rd,
    output logic          q_we,
    output logic          q_is_load
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid   <= 1'b0;
            q_rd      <= '0;
            q_we      <= 1'b0;
            q_is_load <= 1'b0;
        end else if (load) begin
            q_valid   <= d_valid;
            q_rd      <= d_rd;
            q_we      <= d_we;
            q_is_load <= d_is_load;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RV32I 5-stage hazard, stall/flush and EX forwarding controller
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int AW     = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             i_stall,
    input  logic             d_stall,
    input  logic             ex_redirect,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             freeze,
    output fwdmux_sel_t      fwd_a_sel,
    output fwdmux_sel_t      fwd_b_sel,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic FWD_ON = (FWD_EN != 0);

    logic          ex_valid, ex_we, ex_is_load;
    logic [AW-1:0] ex_rd;
    logic          mem_valid, mem_we, mem_is_load;
    logic [AW-1:0] mem_rd;
    logic          wb_valid, wb_we, wb_is_load_unused;
    logic [AW-1:0] wb_rd;
    logic [AW-1:0] ex_rs1, ex_rs2;
    logic          ex_uses_rs1, ex_uses_rs2;
    logic          advance;
    logic          raw_hazard, raw_stall;

    // x0 is hardwired zero, so it is never a producer.
    function automatic logic writes_reg(input logic v, input logic we,
                                        input logic [AW-1:0] rd, input logic [AW-1:0] r);
        return v & we & (rd == r) & (r != '0);
    endfunction

    assign freeze  = d_stall;
    assign advance = ~freeze;

    hazard_stage_meta #(.AW(AW)) u_ex (
        .clk       (clk),
        .rst       (rst),
        .load      (advance),
        .d_valid   (id_valid & ~bubble_ex),
        .d_rd      (id_rd),
        .d_we      (id_we),
        .d_is_load (id_is_load),
        .q_valid   (ex_valid),
        .q_rd      (ex_rd),
        .q_we      (ex_we),
        .q_is_load (ex_is_load)
    );

    hazard_stage_meta #(.AW(AW)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .load      (advance),
        .d_valid   (ex_valid),
        .d_rd      (ex_rd),
        .d_we      (ex_we),
        .d_is_load (ex_is_load),
        .q_valid   (mem_valid),
        .q_rd      (mem_rd),
        .q_we      (mem_we),
        .q_is_load (mem_is_load)
    );

    hazard_stage_meta #(.AW(AW)) u_wb (
        .clk       (clk),
        .rst       (rst),
        .load      (advance),
        .d_valid   (mem_valid),
        .d_rd      (mem_rd),
        .d_we      (mem_we),
        .d_is_load (mem_is_load),
        .q_valid   (wb_valid),
        .q_rd      (wb_rd),
        .q_we      (wb_we),
        .q_is_load (wb_is_load_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_uses_rs1 <= 1'b0;
            ex_uses_rs2 <= 1'b0;
        end else if (advance) begin
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_uses_rs1 <= id_uses_rs1;
            ex_uses_rs2 <= id_uses_rs2;
        end
    end

    logic ex_hit_a, ex_hit_b, any_hit_a, any_hit_b;
    logic load_use, any_raw;

    assign ex_hit_a  = id_uses_rs1 & writes_reg(ex_valid, ex_we, ex_rd, id_rs1);
    assign ex_hit_b  = id_uses_rs2 & writes_reg(ex_valid, ex_we, ex_rd, id_rs2);
    // Without write-through a WB producer is still invisible to an ID regfile read.
    assign any_hit_a = id_uses_rs1 & (writes_reg(ex_valid, ex_we, ex_rd, id_rs1) |
                                      writes_reg(mem_valid, mem_we, mem_rd, id_rs1) |
                                      writes_reg(wb_valid, wb_we, wb_rd, id_rs1));
    assign any_hit_b = id_uses_rs2 & (writes_reg(ex_valid, ex_we, ex_rd, id_rs2) |
                                      writes_reg(mem_valid, mem_we, mem_rd, id_rs2) |
                                      writes_reg(wb_valid, wb_we, wb_rd, id_rs2));

    assign load_use   = ex_is_load & (ex_hit_a | ex_hit_b);
    assign any_raw    = any_hit_a | any_hit_b;
    assign raw_hazard = id_valid & (FWD_ON ? load_use : any_raw);
    assign raw_stall  = raw_hazard & ~freeze & ~ex_redirect;

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        if (freeze) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (raw_hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (i_stall) begin
            stall_if = 1'b1;
            flush_id = 1'b1;
        end
    end

    // A MEM-stage load has no data yet; the interlock keeps that case from reaching EX.
    always_comb begin
        fwd_a_sel = fwd_select(FWD_ON & ex_valid & ex_uses_rs1,
                               writes_reg(mem_valid, mem_we, mem_rd, ex_rs1) & ~mem_is_load,
                               writes_reg(wb_valid, wb_we, wb_rd, ex_rs1));
        fwd_b_sel = fwd_select(FWD_ON & ex_valid & ex_uses_rs2,
                               writes_reg(mem_valid, mem_we, mem_rd, ex_rs2) & ~mem_is_load,
                               writes_reg(wb_valid, wb_we, wb_rd, ex_rs2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (raw_stall | freeze)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (ex_redirect & ~freeze)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
